// File: rtl/multiplier_interface_pkg.sv
// Shared types and constants for the multiplier_interface block: FSM states and
// operand/result widths of the 8x8 shift-add datapath.
package multiplier_interface_pkg;

   localparam int OPERAND_W  = 8;
   localparam int RESULT_W   = 16;
   localparam int MULT_ITER  = 8;
   localparam int ITER_CNT_W = $clog2(MULT_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MULT = 2'd2,
      OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/multiplier_interface_if.sv
// Bus bundle for multiplier_interface: FIFO write side (from the divider) and
// the product valid/ready output side, plus the drop counter.
interface multiplier_interface_if;
   import multiplier_interface_pkg::*;

   logic                write_req;
   logic [RESULT_W-1:0] fifo_write_data;
   logic                full_out;
   logic [RESULT_W-1:0] product;
   logic                out_valid;
   logic                out_ready;
   logic [7:0]          drop_cnt;

   // Upstream producer plus downstream consumer.
   modport master (
      output write_req, fifo_write_data, out_ready,
      input  full_out, product, out_valid, drop_cnt
   );

   // The multiplier_interface block itself.
   modport slave (
      input  write_req, fifo_write_data, out_ready,
      output full_out, product, out_valid, drop_cnt
   );

endinterface

// File: rtl/multiplier_module.sv
// Unsigned 8x8 shift-add multiplier: start loads the operands, exactly MULT_ITER
// iterations follow, done pulses for one cycle with the full 16-bit result.
module multiplier_module
   import multiplier_interface_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [OPERAND_W-1:0] a,
   input  logic [OPERAND_W-1:0] b,
   output logic                 done,
   output logic [RESULT_W-1:0]  result
);

   localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(MULT_ITER - 1);

   logic [RESULT_W-1:0]   acc;
   logic [RESULT_W-1:0]   mcand;
   logic [OPERAND_W-1:0]  mplier;
   logic [ITER_CNT_W-1:0] iter;
   logic                  busy;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         iter   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            acc    <= '0;
            mcand  <= {{(RESULT_W-OPERAND_W){1'b0}}, a};
            mplier <= b;
            iter   <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            if (mplier[0]) begin
               acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            iter   <= iter + 1'b1;
            // The last add lands in acc on this same edge, so done and the
            // final result become visible together.
            if (iter == LAST_ITER) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign result = acc;

endmodule

// File: rtl/multiplier_interface.sv
// Buffers divider results in a FIFO and multiplies quotient by remainder.
// Optional drop counter: define MULTIPLIER_INTERFACE_DROP_CNT_EN.
module multiplier_interface
   import multiplier_interface_pkg::*;
#(
   parameter int FIFO_DEPTH = 16   // power of two, at least 4
) (
   input  logic                  clk,
   input  logic                  rst,
   multiplier_interface_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // ---------------- FIFO ----------------
   logic [RESULT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic [RESULT_W-1:0] rd_data;
   logic                full;
   logic                empty;
   logic                wr_en;
   logic                rd_en;

   // Extra pointer MSB tells a full FIFO apart from an empty one.
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign wr_en = bus.write_req && !full;

   // NOTE: the storage array has no reset; pointers alone define its contents,
   // which keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[PTR_W-1:0]] <= bus.fifo_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[PTR_W-1:0]];
         end
      end
   end

   // ---------------- control FSM ----------------
   state_t              state;
   state_t              state_nxt;
   logic                mult_start;
   logic                mult_done;
   logic [RESULT_W-1:0] mult_result;
   logic                load_prod;
   logic                accept;
   logic [RESULT_W-1:0] product_q;
   logic                out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt  = state;
      rd_en      = 1'b0;
      mult_start = 1'b0;
      load_prod  = 1'b0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               rd_en     = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            mult_start = 1'b1;
            state_nxt  = MULT;
         end
         MULT: begin
            if (mult_done) begin
               load_prod = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (out_valid_q && bus.out_ready) begin
               accept    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   multiplier_module u_mult (
      .clk    (clk),
      .rst    (rst),
      .start  (mult_start),
      .a      (rd_data[RESULT_W-1:OPERAND_W]),
      .b      (rd_data[OPERAND_W-1:0]),
      .done   (mult_done),
      .result (mult_result)
   );

   // Product is held stable from capture until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (load_prod) begin
         product_q   <= mult_result;
         out_valid_q <= 1'b1;
      end else if (accept) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.full_out  = full;
   assign bus.product   = product_q;
   assign bus.out_valid = out_valid_q;

   // ---------------- drop counter ----------------
`ifdef MULTIPLIER_INTERFACE_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (bus.write_req && full && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign bus.drop_cnt = drop_cnt_q;
`else
   assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_multiplier_interface.sv
// Directed self-checking bench for multiplier_interface: latency, arithmetic
// corners, fill/drop/drain, back-to-back throughput, mid-run reset, ready toggling.
module tb_multiplier_interface;

`ifdef MULTIPLIER_INTERFACE_DROP_CNT_EN
   localparam logic [7:0] EXP_DROP = 8'd3;
`else
   localparam logic [7:0] EXP_DROP = 8'd0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cyc;

   multiplier_interface_if bus ();

   multiplier_interface #(.FIFO_DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; all driving and sampling happens here.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic write_word(input logic [15:0] data);
      bus.write_req       = 1'b1;
      bus.fifo_write_data = data;
      tick();
      bus.write_req       = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int lat, output bit timed_out);
      lat       = 0;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         lat++;
         if (bus.out_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      total++;
      if (bus.product !== 16'h0000) begin
         bad++; $display("FAIL reset_product got=%h want=0000", bus.product);
      end
      total++;
      if (bus.full_out !== 1'b0) begin
         bad++; $display("FAIL reset_full got=%b want=0", bus.full_out);
      end
      total++;
      if (bus.drop_cnt !== 8'h00) begin
         bad++; $display("FAIL reset_drop_cnt got=%h want=00", bus.drop_cnt);
      end
   endtask

   task automatic test_latency();
      int lat;
      bit to;
      bus.out_ready = 1'b1;
      write_word(16'h0C05);
      wait_valid(40, lat, to);
      total++;
      if (to || lat != 11) begin
         bad++; $display("FAIL latency got=%0d timeout=%0d want=11", lat, to);
      end
      total++;
      if (bus.product !== 16'h003C) begin
         bad++; $display("FAIL latency_product got=%h want=003c", bus.product);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL valid_one_cycle got=%b want=0", bus.out_valid);
      end
   endtask

   task automatic test_corners();
      logic [15:0] ops [2];
      logic [15:0] exp_p [2];
      int lat;
      bit to;
      ops   = '{16'hFFFF, 16'h007F};
      exp_p = '{16'hFE01, 16'h0000};
      bus.out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         write_word(ops[k]);
         wait_valid(40, lat, to);
         total++;
         if (to || bus.product !== exp_p[k]) begin
            bad++; $display("FAIL corner_%0d got=%h timeout=%0d want=%h", k, bus.product, to, exp_p[k]);
         end
         tick();
      end
   endtask

   task automatic test_fill_drain();
      int n_res;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready       = 1'b0;
      bus.write_req       = 1'b1;
      bus.fifo_write_data = 16'h0101;
      for (int k = 0; k < 20; k++) tick();
      bus.write_req = 1'b0;
      total++;
      if (bus.full_out !== 1'b1) begin
         bad++; $display("FAIL fill_full got=%b want=1", bus.full_out);
      end
      total++;
      if (bus.drop_cnt !== EXP_DROP) begin
         bad++; $display("FAIL drop_cnt got=%0d want=%0d", bus.drop_cnt, EXP_DROP);
      end
      bus.out_ready = 1'b1;
      n_res = 0;
      for (int k = 0; k < 17 * 12 + 60; k++) begin
         if (bus.out_valid) begin
            n_res++;
            total++;
            if (bus.product !== 16'h0001) begin
               bad++; $display("FAIL drain_product_%0d got=%h want=0001", n_res, bus.product);
            end
         end
         tick();
      end
      total++;
      if (n_res != 17) begin
         bad++; $display("FAIL drain_count got=%0d want=17", n_res);
      end
      total++;
      if (bus.full_out !== 1'b0) begin
         bad++; $display("FAIL drain_full got=%b want=0", bus.full_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_p [3];
      int t0;
      int seen;
      int t_seen [3];
      exp_p = '{16'h0006, 16'h0014, 16'h002A};
      bus.out_ready = 1'b1;
      write_word(16'h0203);
      t0 = cyc;
      write_word(16'h0405);
      write_word(16'h0607);
      seen = 0;
      for (int k = 0; k < 80 && seen < 3; k++) begin
         tick();
         if (bus.out_valid) begin
            t_seen[seen] = cyc;
            total++;
            if (bus.product !== exp_p[seen]) begin
               bad++; $display("FAIL b2b_product_%0d got=%h want=%h", seen, bus.product, exp_p[seen]);
            end
            seen++;
         end
      end
      total++;
      if (seen != 3) begin
         bad++; $display("FAIL b2b_count got=%0d want=3", seen);
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (t_seen[k] - t0 != 11 + 12 * k) begin
               bad++; $display("FAIL b2b_time_%0d got=%0d want=%0d", k, t_seen[k] - t0, 11 + 12 * k);
            end
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bit stray;
      int lat;
      bit to;
      bus.out_ready = 1'b1;
      write_word(16'h0505);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (bus.product !== 16'h0000 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL midrst_clear product=%h valid=%b want=0000/0", bus.product, bus.out_valid);
      end
      stray = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.out_valid) stray = 1'b1;
      end
      total++;
      if (stray) begin
         bad++; $display("FAIL midrst_stray_valid got=1 want=0");
      end
      total++;
      if (bus.full_out !== 1'b0) begin
         bad++; $display("FAIL midrst_full got=%b want=0", bus.full_out);
      end
      write_word(16'h0303);
      wait_valid(40, lat, to);
      total++;
      if (to || lat != 11 || bus.product !== 16'h0009) begin
         bad++; $display("FAIL midrst_next got=%h lat=%0d timeout=%0d want=0009/11", bus.product, lat, to);
      end
      tick();
   endtask

   task automatic test_toggle_ready();
      logic [15:0] exp_p [2];
      int idx;
      exp_p = '{16'h006E, 16'h0132};
      bus.out_ready = 1'b0;
      write_word(16'h0A0B);
      write_word(16'h1112);
      idx = 0;
      for (int k = 0; k < 70; k++) begin
         tick();
         bus.out_ready = ~bus.out_ready;
         if (bus.out_valid) begin
            total++;
            if (idx > 1) begin
               bad++; $display("FAIL toggle_extra_valid got=1 want=0");
            end else if (bus.product !== exp_p[idx]) begin
               bad++; $display("FAIL toggle_product_%0d got=%h want=%h", idx, bus.product, exp_p[idx]);
            end
            if (bus.out_ready) idx++;
         end
      end
      total++;
      if (idx != 2) begin
         bad++; $display("FAIL toggle_accepts got=%0d want=2", idx);
      end
      bus.out_ready = 1'b1;
   endtask

   initial begin
      total               = 0;
      bad                 = 0;
      cyc                 = 0;
      rst                 = 1'b1;
      bus.write_req       = 1'b0;
      bus.fifo_write_data = '0;
      bus.out_ready       = 1'b0;
      test_reset();
      test_latency();
      test_corners();
      test_fill_drain();
      test_back_to_back();
      test_reset_mid();
      test_toggle_ready();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
